// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit.
// Ports: clk, reset (sync, active-low), opcode/funct/ALUzero/dm_ready in;
// datapath mux selects, DM/GRF/PC/IR strobes, illegal, state, instr_count out.
module mc_controller #(
  parameter int CNT_W       = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             ALUzero,
  input  logic             dm_ready,
  output logic [1:0]       WACtrl,
  output logic [1:0]       WDCtrl,
  output logic [1:0]       ALUCtrl,
  output logic             ALUBCtrl,
  output logic             EXTCtrl,
  output logic [1:0]       JumpCtrl,
  output logic             DM_WE,
  output logic             DM_RE,
  output logic             GRFWE,
  output logic             PC_WE,
  output logic             IR_WE,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_F = 3'd0;
  localparam logic [2:0] S_D = 3'd1;
  localparam logic [2:0] S_E = 3'd2;
  localparam logic [2:0] S_M = 3'd3;
  localparam logic [2:0] S_W = 3'd4;

  localparam logic [CNT_W-1:0] ONE = 1;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI,
    C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } cls_t;

  function automatic cls_t f_dec(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    cls_t c;
    c = C_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h21:   c = C_ADDU;
          6'h23:   c = C_SUBU;
          6'h08:   c = C_JR;
          default: c = C_ILL;
        endcase
      end
      6'h0d:   c = C_ORI;
      6'h0f:   c = C_LUI;
      6'h23:   c = C_LW;
      6'h2b:   c = C_SW;
      6'h04:   c = C_BEQ;
      6'h02:   c = C_J;
      6'h03:   c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  logic [2:0]       r_state;
  logic [2:0]       w_nstate;
  logic [5:0]       r_op;
  logic [5:0]       r_fn;
  logic [CNT_W-1:0] r_cnt;
  cls_t             w_live;
  cls_t             w_lat;
  logic             w_rdy;
  logic             w_late;

  // DECODE sees the IR directly; later states use the copy
  // latched at the end of DECODE.
  assign w_live = f_dec(opcode, funct);
  assign w_lat  = f_dec(r_op, r_fn);
  assign w_rdy  = MEM_WAIT_EN ? dm_ready : 1'b1;
  assign w_late = (r_state == S_E) || (r_state == S_M) ||
                  (r_state == S_W);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_F;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      if (PC_WE) r_cnt <= r_cnt + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op <= '0;
      r_fn <= '0;
    end else if (r_state == S_D) begin
      r_op <= opcode;
      r_fn <= funct;
    end
  end

  always_comb begin
    w_nstate = S_F;
    case (r_state)
      S_F: w_nstate = S_D;
      S_D: begin
        case (w_live)
          C_J, C_JAL, C_JR, C_ILL: w_nstate = S_F;
          default:                 w_nstate = S_E;
        endcase
      end
      S_E: begin
        case (w_lat)
          C_LW, C_SW: w_nstate = S_M;
          C_BEQ:      w_nstate = S_F;
          default:    w_nstate = S_W;
        endcase
      end
      S_M: begin
        if (!w_rdy)             w_nstate = S_M;
        else if (w_lat == C_LW) w_nstate = S_W;
        else                    w_nstate = S_F;
      end
      S_W:     w_nstate = S_F;
      default: w_nstate = S_F;
    endcase
  end

  always_comb begin
    WACtrl   = 2'b00;
    WDCtrl   = 2'b00;
    ALUCtrl  = 2'b00;
    ALUBCtrl = 1'b0;
    EXTCtrl  = 1'b0;
    JumpCtrl = 2'b00;
    DM_WE    = 1'b0;
    DM_RE    = 1'b0;
    GRFWE    = 1'b0;
    PC_WE    = 1'b0;
    IR_WE    = 1'b0;
    illegal  = 1'b0;
    if (reset) begin
      // Selects stay put from EXEC to WB so the datapath is stable.
      if (w_late) begin
        case (w_lat)
          C_ADDU: WACtrl = 2'b01;
          C_SUBU: begin
            WACtrl  = 2'b01;
            ALUCtrl = 2'b01;
          end
          C_ORI: begin
            ALUBCtrl = 1'b1;
            ALUCtrl  = 2'b10;
          end
          C_LUI: begin
            ALUBCtrl = 1'b1;
            ALUCtrl  = 2'b11;
          end
          C_LW: begin
            ALUBCtrl = 1'b1;
            EXTCtrl  = 1'b1;
            WDCtrl   = 2'b01;
          end
          C_SW: begin
            ALUBCtrl = 1'b1;
            EXTCtrl  = 1'b1;
          end
          C_BEQ: begin
            ALUCtrl = 2'b01;
            EXTCtrl = 1'b1;
          end
          default: ;
        endcase
      end
      case (r_state)
        S_F: IR_WE = 1'b1;
        S_D: begin
          case (w_live)
            C_J: begin
              PC_WE    = 1'b1;
              JumpCtrl = 2'b10;
            end
            C_JAL: begin
              GRFWE    = 1'b1;
              WACtrl   = 2'b10;
              WDCtrl   = 2'b10;
              PC_WE    = 1'b1;
              JumpCtrl = 2'b10;
            end
            C_JR: begin
              PC_WE    = 1'b1;
              JumpCtrl = 2'b11;
            end
            C_ILL: begin
              illegal = 1'b1;
              PC_WE   = 1'b1;
            end
            default: ;
          endcase
        end
        S_E: begin
          if (w_lat == C_BEQ) begin
            PC_WE    = 1'b1;
            JumpCtrl = ALUzero ? 2'b01 : 2'b00;
          end
        end
        S_M: begin
          if (w_lat == C_LW) begin
            DM_RE = 1'b1;
          end else if (w_lat == C_SW) begin
            DM_WE = 1'b1;
            PC_WE = w_rdy;
          end
        end
        S_W: begin
          GRFWE = 1'b1;
          PC_WE = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = r_state;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized and directed bench for mc_controller.
// Per-cycle expectations come from a table of instruction sequences.
module tb_mc_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rw;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        ALUzero;
  logic        dm_ready;
  logic [1:0]  WACtrl, WDCtrl, ALUCtrl, JumpCtrl;
  logic        ALUBCtrl, EXTCtrl;
  logic        DM_WE, DM_RE, GRFWE, PC_WE, IR_WE, illegal;
  logic [2:0]  state;
  logic [31:0] instr_count;

  logic [1:0]  w_wa, w_wd, w_alu, w_jc;
  logic        w_alub, w_ext;
  logic        w_we, w_re, w_grf, w_pc, w_ir, w_ill;
  logic [2:0]  w_state;
  logic [1:0]  w_cnt;

  mc_controller u_dut (
    .clk(clk), .reset(rst), .opcode(opcode), .funct(funct),
    .ALUzero(ALUzero), .dm_ready(dm_ready),
    .WACtrl(WACtrl), .WDCtrl(WDCtrl), .ALUCtrl(ALUCtrl),
    .ALUBCtrl(ALUBCtrl), .EXTCtrl(EXTCtrl), .JumpCtrl(JumpCtrl),
    .DM_WE(DM_WE), .DM_RE(DM_RE), .GRFWE(GRFWE), .PC_WE(PC_WE),
    .IR_WE(IR_WE), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  mc_controller #(.CNT_W(2), .MEM_WAIT_EN(1'b0)) u_w (
    .clk(clk), .reset(rw), .opcode(opcode), .funct(funct),
    .ALUzero(ALUzero), .dm_ready(dm_ready),
    .WACtrl(w_wa), .WDCtrl(w_wd), .ALUCtrl(w_alu),
    .ALUBCtrl(w_alub), .EXTCtrl(w_ext), .JumpCtrl(w_jc),
    .DM_WE(w_we), .DM_RE(w_re), .GRFWE(w_grf), .PC_WE(w_pc),
    .IR_WE(w_ir), .illegal(w_ill), .state(w_state),
    .instr_count(w_cnt)
  );

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3;
  localparam int K_LUI = 4, K_LW = 5, K_SW = 6, K_BEQ = 7;
  localparam int K_J = 8, K_JAL = 9, K_ILL = 10;

  logic [5:0] OPS [10] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f,
                           6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
  logic [5:0] FNS [10] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00,
                           6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  typedef struct {
    logic [2:0] st;
    logic       ir, pc, grf, re, we, ill;
    logic [1:0] jc, wa, wd, alu;
    logic       alub, ext;
    bit         c_alu, c_ext, c_wawd;
  } exp_t;

  int          checks;
  int          failures;
  logic [31:0] mcnt;
  int          wcnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [5:0] op,
                                 input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h21) return K_ADDU;
      if (fn == 6'h23) return K_SUBU;
      if (fn == 6'h08) return K_JR;
      return K_ILL;
    end
    for (int i = 3; i < 10; i++)
      if (OPS[i] == op) return i;
    return K_ILL;
  endfunction

  function automatic exp_t expect_at(input int k, input logic [2:0] st,
                                     input logic z, input logic rdy);
    exp_t e;
    e = '{default: 0};
    e.st = st;
    case (st)
      3'd0: e.ir = 1;
      3'd1: begin
        if (k == K_J) begin e.pc = 1; e.jc = 2; end
        if (k == K_JR) begin e.pc = 1; e.jc = 3; end
        if (k == K_ILL) begin e.pc = 1; e.ill = 1; end
        if (k == K_JAL) begin
          e.pc = 1; e.jc = 2; e.grf = 1;
          e.wa = 2; e.wd = 2; e.c_wawd = 1;
        end
      end
      3'd2: if (k == K_BEQ) begin e.pc = 1; e.jc = z ? 2'd1 : 2'd0; end
      3'd3: begin
        if (k == K_LW) e.re = 1;
        else begin e.we = 1; e.pc = rdy; end
      end
      default: begin
        e.grf = 1; e.pc = 1; e.c_wawd = 1;
        e.wa = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        e.wd = (k == K_LW) ? 2'd1 : 2'd0;
      end
    endcase
    if (st >= 3'd2 && k != K_SW) begin
      e.c_alu = 1;
      case (k)
        K_SUBU, K_BEQ: e.alu = 1;
        K_ORI:         e.alu = 2;
        K_LUI:         e.alu = 3;
        default:       e.alu = 0;
      endcase
      e.alub = (k == K_ORI || k == K_LUI || k == K_LW);
      e.c_ext = (k == K_ORI || k == K_LUI || k == K_LW || k == K_BEQ);
      e.ext = (k == K_LW || k == K_BEQ);
    end
    return e;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int stall,
                           input string tag);
    int k;
    int mi;
    logic [2:0] seq[$];
    exp_t e;
    k = kind_of(op, fn);
    mi = 0;
    seq.push_back(3'd0);
    seq.push_back(3'd1);
    if (k <= K_BEQ && k != K_JR) seq.push_back(3'd2);
    if (k == K_LW || k == K_SW)
      for (int s = 0; s <= stall; s++) seq.push_back(3'd3);
    if (k == K_ADDU || k == K_SUBU || k == K_ORI ||
        k == K_LUI || k == K_LW) seq.push_back(3'd4);
    foreach (seq[i]) begin
      logic rdy;
      rdy = 1'b1;
      if (seq[i] == 3'd3) begin
        rdy = (mi >= stall);
        mi++;
        dm_ready = rdy;
      end else begin
        dm_ready = 1'($urandom_range(0, 1));
      end
      if (seq[i] == 3'd1) begin
        opcode = op;
        funct  = fn;
      end else begin
        opcode = 6'($urandom_range(0, 63));
        funct  = 6'($urandom_range(0, 63));
      end
      ALUzero = z;
      #2;
      e = expect_at(k, seq[i], z, rdy);
      chk({tag, "/state"}, 32'(state), 32'(e.st));
      chk({tag, "/ir_we"}, 32'(IR_WE), 32'(e.ir));
      chk({tag, "/pc_we"}, 32'(PC_WE), 32'(e.pc));
      chk({tag, "/grfwe"}, 32'(GRFWE), 32'(e.grf));
      chk({tag, "/dm_re"}, 32'(DM_RE), 32'(e.re));
      chk({tag, "/dm_we"}, 32'(DM_WE), 32'(e.we));
      chk({tag, "/illegal"}, 32'(illegal), 32'(e.ill));
      chk({tag, "/count"}, instr_count, mcnt);
      if (e.pc) chk({tag, "/jump"}, 32'(JumpCtrl), 32'(e.jc));
      if (e.c_wawd) begin
        chk({tag, "/wa"}, 32'(WACtrl), 32'(e.wa));
        chk({tag, "/wd"}, 32'(WDCtrl), 32'(e.wd));
      end
      if (e.c_alu) begin
        chk({tag, "/alu"}, 32'(ALUCtrl), 32'(e.alu));
        chk({tag, "/alub"}, 32'(ALUBCtrl), 32'(e.alub));
      end
      if (e.c_ext) chk({tag, "/ext"}, 32'(EXTCtrl), 32'(e.ext));
      @(posedge clk);
      #1;
      if (e.pc) mcnt = mcnt + 1;
    end
    chk({tag, "/count_end"}, instr_count, mcnt);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/strobes"},
        32'({DM_WE, DM_RE, GRFWE, PC_WE, IR_WE, illegal}), 32'd0);
    chk({tag, "/selects"},
        32'({WACtrl, WDCtrl, ALUCtrl, ALUBCtrl, EXTCtrl, JumpCtrl}),
        32'd0);
  endtask

  initial begin
    logic [5:0] rop, rfn;
    int r;
    checks   = 0;
    failures = 0;
    mcnt     = 0;
    wcnt     = 0;
    rst      = 1'b0;
    rw       = 1'b0;
    opcode   = 6'h00;
    funct    = 6'h00;
    ALUzero  = 1'b0;
    dm_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/state", 32'(state), 32'd0);
    chk("reset/count", instr_count, 32'd0);
    chk_quiet("reset");
    rst = 1'b1;

    run_instr(6'h00, 6'h21, 1'b0, 0, "addu");
    run_instr(6'h23, 6'h00, 1'b0, 3, "lw_stall3");
    run_instr(6'h00, 6'h23, 1'b0, 0, "subu");
    run_instr(6'h0d, 6'h00, 1'b0, 0, "ori");
    run_instr(6'h0f, 6'h00, 1'b0, 0, "lui");
    run_instr(6'h2b, 6'h00, 1'b0, 2, "sw_stall2");
    run_instr(6'h2b, 6'h00, 1'b0, 0, "sw_fast");
    run_instr(6'h04, 6'h00, 1'b1, 0, "beq_taken");
    run_instr(6'h04, 6'h00, 1'b0, 0, "beq_not");
    run_instr(6'h03, 6'h00, 1'b0, 0, "jal");
    run_instr(6'h00, 6'h08, 1'b0, 0, "jr");
    run_instr(6'h02, 6'h00, 1'b0, 0, "j");
    run_instr(6'h3f, 6'h15, 1'b0, 0, "ill_3f");

    opcode   = 6'h23;
    funct    = 6'h00;
    dm_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid/in_mem", 32'(state), 32'd3);
    chk("rst_mid/dm_re", 32'(DM_RE), 32'd1);
    rst = 1'b0;
    #1;
    chk_quiet("rst_mid0");
    @(posedge clk);
    #1;
    chk_quiet("rst_mid1");
    chk("rst_mid/state", 32'(state), 32'd0);
    chk("rst_mid/count", instr_count, 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    mcnt = 0;
    #1;
    chk("rst_rel/state", 32'(state), 32'd0);
    chk("rst_rel/ir_we", 32'(IR_WE), 32'd1);
    chk("rst_rel/count", instr_count, 32'd0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 10);
      if (r < 10) begin
        rop = OPS[r];
        rfn = FNS[r];
      end else begin
        rop = 6'h3f;
        rfn = 6'h00;
        for (int t = 0; t < 64; t++) begin
          rop = 6'($urandom_range(0, 63));
          rfn = 6'($urandom_range(0, 63));
          if (kind_of(rop, rfn) == K_ILL) break;
        end
      end
      run_instr(rop, rfn, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), "rand");
    end

    rst = 1'b0;
    rw  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      opcode = 6'h3f;
      funct  = 6'($urandom_range(0, 63));
      #1;
      chk("wrap/fetch", 32'(w_state), 32'd0);
      chk("wrap/ir_we", 32'(w_ir), 32'd1);
      chk("wrap/main_pc", 32'(PC_WE), 32'd0);
      @(posedge clk);
      #1;
      chk("wrap/decode", 32'(w_state), 32'd1);
      chk("wrap/illegal", 32'(w_ill), 32'd1);
      chk("wrap/pc_we", 32'(w_pc), 32'd1);
      chk("wrap/jump", 32'(w_jc), 32'd0);
      chk("wrap/grf_dm", 32'({w_grf, w_we}), 32'd0);
      @(posedge clk);
      #1;
      wcnt = (wcnt + 1) % 4;
      chk("wrap/count", 32'(w_cnt), 32'(wcnt));
    end

    opcode   = 6'h23;
    funct    = 6'h00;
    dm_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("nowait/state", 32'(w_state), 32'(j));
      if (j == 3) chk("nowait/dm_re", 32'(w_re), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("nowait/back", 32'(w_state), 32'd0);
    chk("nowait/count", 32'(w_cnt), 32'((wcnt + 1) % 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control unit that sits directly upstream of the CPU datapath.
- Consumes the datapath's opcode, funct and ALUzero outputs.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath control input, plus PC and IR write enables.
- Adds a data-memory ready handshake so DM can stall the MEM state, and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- MEM_WAIT_EN, 1, 1 = honour dm_ready; 0 = treat dm_ready as always 1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- opcode  input  6  Instr[31:26] from datapath
- funct  input  6  Instr[5:0] from datapath
- ALUzero  input  1  ALU zero flag from datapath
- dm_ready  input  1  DM completes the current access this cycle
- WACtrl  output  2  00 rt, 01 rd, 10 $31
- WDCtrl  output  2  00 ALUResult, 01 ReadData, 10 PC4
- ALUCtrl  output  2  00 add, 01 sub, 10 or, 11 lui (B<<16)
- ALUBCtrl  output  1  0 RD2, 1 EXTData
- EXTCtrl  output  1  0 zero-extend, 1 sign-extend
- JumpCtrl  output  2  00 PC4, 01 branch target, 10 j-target, 11 RD1
- DM_WE  output  1  DM write strobe
- DM_RE  output  1  DM read strobe
- GRFWE  output  1  register-file write strobe
- PC_WE  output  1  PC load enable; exactly one pulse per instruction
- IR_WE  output  1  instruction register load
- illegal  output  1  one-cycle pulse on an unrecognised instruction
- state  output  3  current state (debug)
- instr_count  output  CNT_W  retired instructions

Behaviour:
- Reset: reset low at a rising clk edge -> state=FETCH (000) and instr_count=0.
  - While reset is low, all strobes (DM_WE, DM_RE, GRFWE, PC_WE, IR_WE, illegal) are forced 0 combinationally.
  - Mux selects are 0 while reset is low.
  - Reset in any state, including mid-MEM stall, abandons the instruction with no GRF or PC write.
- States: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100. Codes 101-111 go to FETCH on the next edge with no strobes.
- FETCH: IR_WE=1. Latch nothing else. Next state is DECODE.
- DECODE: latch opcode/funct into internal registers. All later states decode the latched copy.
- Decoding:
  - addu: 000000/100001
  - subu: 000000/100011
  - jr: 000000/001000
  - ori: 001101
  - lui: 001111
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - j: 000010
  - jal: 000011
- Sequences (PC_WE with JumpCtrl=00 unless stated):
  - addu/subu: F,D,E,WB. EXEC: ALUBCtrl=0, ALUCtrl=00/01. WB: WACtrl=01, WDCtrl=00, GRFWE=1, PC_WE=1. 4 cycles.
  - ori/lui: F,D,E,WB. ALUBCtrl=1, EXTCtrl=0, ALUCtrl=10/11. WB: WACtrl=00, WDCtrl=00, GRFWE=1, PC_WE=1. 4 cycles.
  - lw: F,D,E,MEM,WB. ALUBCtrl=1, EXTCtrl=1, ALUCtrl=00. MEM: DM_RE=1 held until dm_ready. WB: WACtrl=00, WDCtrl=01, GRFWE=1, PC_WE=1. 5 cycles minimum.
  - sw: F,D,E,MEM. MEM: DM_WE=1 held until dm_ready. PC_WE=1 in the cycle dm_ready=1 (Mealy), then go to FETCH. 4 cycles minimum.
  - beq: F,D,E. EXEC: ALUBCtrl=0, ALUCtrl=01, EXTCtrl=1, PC_WE=1, JumpCtrl=ALUzero?01:00 (Mealy on ALUzero). 3 cycles.
  - j: F,D. DECODE: PC_WE=1, JumpCtrl=10. 2 cycles.
  - jal: F,D. DECODE: GRFWE=1, WACtrl=10, WDCtrl=10, PC_WE=1, JumpCtrl=10. 2 cycles.
  - jr: F,D. DECODE: PC_WE=1, JumpCtrl=11. 2 cycles.
  - Unknown: F,D. DECODE: illegal=1, PC_WE=1, JumpCtrl=00 (treated as nop).
- Mux selects hold their instruction values in every state from EXEC onward, so datapath values stay stable through MEM and WB.
- dm_ready:
  - Sampled only in MEM; ignored elsewhere.
  - dm_ready high on MEM entry means a single MEM cycle.
  - No timeout.
  - MEM_WAIT_EN=0 forces single-cycle MEM.
- instr_count increments by 1 on every edge where PC_WE=1. It wraps modulo 2^CNT_W.
- GRFWE, DM_WE and PC_WE are never asserted in FETCH. At most one PC_WE pulse per instruction.

Test Plan:
- Reset low 2 cycles mid-lw MEM stall (dm_ready=0) -> all strobes 0 during reset; state=000, instr_count=0 after release; next cycle IR_WE=1.
- addu (opcode 000000, funct 100001) -> states 000,001,010,100. In WB: GRFWE=1, WACtrl=01, WDCtrl=00, PC_WE=1. instr_count 0->1.
- lw with dm_ready low 3 MEM cycles, then high -> DM_RE=1 for 4 cycles. WB: WDCtrl=01, GRFWE=1. Total 8 cycles; exactly one PC_WE.
- beq with ALUzero=1, then ALUzero=0 -> EXEC PC_WE=1 with JumpCtrl=01, then 00. GRFWE stays 0. 3 cycles each.
- jal then jr -> DECODE: GRFWE=1, WACtrl=10, WDCtrl=10, JumpCtrl=10; then JumpCtrl=11. 2 cycles each; instr_count +2.
- opcode 111111 -> illegal pulses 1 cycle in DECODE, PC_WE=1 with JumpCtrl=00, no GRFWE/DM_WE. Preload instr_count=FFFFFFFF -> wraps to 0.
